gpr_write_controller: RTL and testbench

- Sole owner of the general purpose register file's single write port: write_enable, write_index, write_data.
- Translates x86 register encodings to register-file indices.
- Merges 8-bit and 16-bit writes into the unchanged 32-bit register contents.
- Shares the port between execute-stage writeback and a POPA/POPAD burst sequencer; sits between the execute/stack units and the register file.

---
 rtl/gpr_write_controller.sv | 139 +++++++++++++
 tb/tb_gpr_write_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gpr_write_controller.sv
// Single write-port owner for the GPR file: maps x86 encodings to file indices,
// merges partial-width writes, and arbitrates writeback against POPA/POPAD bursts.
module gpr_write_controller #(
  parameter int POPA_SLOTS = 8,
  parameter int ESP_SLOT   = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wb_valid,
  output logic         wb_ready,
  input  logic [2:0]   wb_reg,
  input  logic [1:0]   wb_size,
  input  logic [31:0]  wb_data,
  input  logic         popa_start,
  input  logic         popa_dword,
  output logic         popa_busy,
  input  logic         popa_data_valid,
  output logic         popa_data_ready,
  input  logic [31:0]  popa_data,
  output logic         popa_done,
  input  logic [255:0] reg_snapshot,
  output logic         write_enable,
  output logic [2:0]   write_index,
  output logic [31:0]  write_data
);

  localparam int SW = (POPA_SLOTS > 1) ? $clog2(POPA_SLOTS) : 1;
  localparam logic [SW-1:0] ESP_IDX  = SW'(ESP_SLOT);
  localparam logic [SW-1:0] LAST_IDX = SW'(POPA_SLOTS - 1);

  typedef enum logic {S_IDLE, S_POPA} state_t;

  state_t        r_state;
  logic [SW-1:0] r_slot;
  logic          r_dword;

  logic          w_is_popa;
  logic [2:0]    w_popa_enc;
  logic [2:0]    w_enc;
  logic [1:0]    w_size;
  logic [31:0]   w_din;
  logic [2:0]    w_target;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;
  logic          w_wb_fire;
  logic          w_popa_fire;
  logic          w_write;

  // x86 dword/word encoding (EAX,ECX,EDX,EBX,ESP,EBP,ESI,EDI) to file index
  function automatic logic [2:0] map_full(input logic [2:0] enc);
    case (enc)
      3'd0:    map_full = 3'd0;
      3'd1:    map_full = 3'd2;
      3'd2:    map_full = 3'd3;
      3'd3:    map_full = 3'd1;
      3'd4:    map_full = 3'd7;
      3'd5:    map_full = 3'd6;
      3'd6:    map_full = 3'd4;
      default: map_full = 3'd5;
    endcase
  endfunction

  assign w_is_popa       = (r_state == S_POPA);
  assign wb_ready        = reset && (r_state == S_IDLE);
  assign popa_busy       = w_is_popa;
  assign popa_data_ready = w_is_popa;

  // Burst pops EDI first and EAX last, i.e. encoding 7 down to 0
  assign w_popa_enc = 3'd7 - 3'(r_slot);

  always_comb begin
    w_enc  = w_is_popa ? w_popa_enc : wb_reg;
    w_size = w_is_popa ? (r_dword ? 2'b10 : 2'b01) : wb_size;
    w_din  = w_is_popa ? popa_data : wb_data;

    // Byte encodings 4..7 alias the high byte of A,C,D,B
    w_target = (w_size == 2'b00) ? map_full({1'b0, w_enc[1:0]}) : map_full(w_enc);

    // The register file has not absorbed last cycle's write yet
    if (write_enable && (write_index == w_target))
      w_old = write_data;
    else
      w_old = reg_snapshot[{w_target, 5'b00000} +: 32];

    case (w_size)
      2'b00:   w_merged = w_enc[2] ? {w_old[31:16], w_din[7:0], w_old[7:0]}
                                   : {w_old[31:8], w_din[7:0]};
      2'b01:   w_merged = {w_old[31:16], w_din[15:0]};
      default: w_merged = w_din;
    endcase
  end

  assign w_wb_fire   = wb_valid && wb_ready;
  assign w_popa_fire = w_is_popa && popa_data_valid;
  assign w_write     = (w_wb_fire && (wb_size != 2'b11)) ||
                       (w_popa_fire && (r_slot != ESP_IDX));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_slot       <= '0;
      r_dword      <= 1'b0;
      popa_done    <= 1'b0;
      write_enable <= 1'b0;
      write_index  <= 3'd0;
      write_data   <= 32'd0;
    end else begin
      popa_done    <= 1'b0;
      write_enable <= w_write;
      if (w_write) begin
        write_index <= w_target;
        write_data  <= w_merged;
      end

      case (r_state)
        S_IDLE: begin
          if (popa_start) begin
            r_state <= S_POPA;
            r_dword <= popa_dword;
            r_slot  <= '0;
          end
        end
        S_POPA: begin
          if (popa_data_valid) begin
            if (r_slot == LAST_IDX) begin
              r_state   <= S_IDLE;
              r_slot    <= '0;
              popa_done <= 1'b1;
            end else begin
              r_slot <= r_slot + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_write_controller.sv
// Directed bench for gpr_write_controller: writeback merges, forwarding, POPA/POPAD bursts, reset abort.
module tb_gpr_write_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         wb_valid;
  logic         wb_ready;
  logic [2:0]   wb_reg;
  logic [1:0]   wb_size;
  logic [31:0]  wb_data;
  logic         popa_start;
  logic         popa_dword;
  logic         popa_busy;
  logic         popa_data_valid;
  logic         popa_data_ready;
  logic [31:0]  popa_data;
  logic         popa_done;
  logic [255:0] reg_snapshot;
  logic         write_enable;
  logic [2:0]   write_index;
  logic [31:0]  write_data;

  int n_checks = 0;
  int n_fail   = 0;
  int popa_idx[8] = '{5, 4, 6, 7, 1, 3, 2, 0};

  gpr_write_controller dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_size(wb_size), .wb_data(wb_data),
    .popa_start(popa_start), .popa_dword(popa_dword), .popa_busy(popa_busy),
    .popa_data_valid(popa_data_valid), .popa_data_ready(popa_data_ready),
    .popa_data(popa_data), .popa_done(popa_done), .reg_snapshot(reg_snapshot),
    .write_enable(write_enable), .write_index(write_index), .write_data(write_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [2:0] idx, input logic [31:0] data);
    check({tag, ".we"}, 32'(write_enable), 32'd1);
    check({tag, ".idx"}, 32'(write_index), 32'(idx));
    check({tag, ".data"}, write_data, data);
  endtask

  initial begin
    reset = 1'b0; wb_valid = 1'b0; wb_reg = 3'd0; wb_size = 2'b00; wb_data = 32'd0;
    popa_start = 1'b0; popa_dword = 1'b0; popa_data_valid = 1'b0; popa_data = 32'd0;
    reg_snapshot = '0;

    // Reset state
    #12;
    check("rst.we", 32'(write_enable), 32'd0);
    check("rst.idx", 32'(write_index), 32'd0);
    check("rst.data", write_data, 32'd0);
    check("rst.wb_ready", 32'(wb_ready), 32'd0);
    check("rst.busy", 32'(popa_busy), 32'd0);
    check("rst.done", 32'(popa_done), 32'd0);
    check("rst.dready", 32'(popa_data_ready), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("idle.wb_ready", 32'(wb_ready), 32'd1);

    // AH byte write into EAX
    reg_snapshot[31:0] = 32'h1122_3344;
    wb_valid = 1'b1; wb_reg = 3'd4; wb_size = 2'b00; wb_data = 32'h0000_00AB;
    tick();
    wb_valid = 1'b0;
    check_write("ah", 3'd0, 32'h1122_AB44);
    tick();
    check("ah.idle_we", 32'(write_enable), 32'd0);

    // CX word then CL byte, second relies on forwarding
    reg_snapshot[95:64] = 32'hCAFE_0000;
    wb_valid = 1'b1; wb_reg = 3'd1; wb_size = 2'b01; wb_data = 32'h0000_BEEF;
    tick();
    check_write("cx", 3'd2, 32'hCAFE_BEEF);
    wb_reg = 3'd1; wb_size = 2'b00; wb_data = 32'h0000_0055;
    tick();
    check_write("cl", 3'd2, 32'hCAFE_BE55);

    // ESI dword, then reserved size
    wb_reg = 3'd6; wb_size = 2'b10; wb_data = 32'hDEAD_BEEF;
    tick();
    check_write("esi", 3'd4, 32'hDEAD_BEEF);
    wb_size = 2'b11; wb_reg = 3'd0; wb_data = 32'h1234_5678;
    check("rsv.wb_ready", 32'(wb_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    check("rsv.we", 32'(write_enable), 32'd0);

    // POPAD, data 1..8, valid held high
    popa_start = 1'b1; popa_dword = 1'b1;
    tick();
    popa_start = 1'b0;
    check("popad.busy", 32'(popa_busy), 32'd1);
    check("popad.dready", 32'(popa_data_ready), 32'd1);
    check("popad.wb_ready", 32'(wb_ready), 32'd0);
    popa_data_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      popa_data = 32'(k + 1);
      tick();
      if (k == 3) begin
        check($sformatf("popad.s%0d.we", k), 32'(write_enable), 32'd0);
      end else begin
        check_write($sformatf("popad.s%0d", k), 3'(popa_idx[k]), 32'(k + 1));
      end
      check($sformatf("popad.s%0d.done", k), 32'(popa_done), (k == 7) ? 32'd1 : 32'd0);
      check($sformatf("popad.s%0d.busy", k), 32'(popa_busy), (k == 7) ? 32'd0 : 32'd1);
      check($sformatf("popad.s%0d.wb_ready", k), 32'(wb_ready), (k == 7) ? 32'd1 : 32'd0);
    end
    popa_data_valid = 1'b0;
    tick();
    check("popad.post_done", 32'(popa_done), 32'd0);
    check("popad.post_we", 32'(write_enable), 32'd0);

    // POPA 16-bit with valid on every other cycle
    reg_snapshot = '0;
    reg_snapshot[63:32] = 32'hFFFF_0000;
    popa_start = 1'b1; popa_dword = 1'b0;
    tick();
    popa_start = 1'b0;
    begin
      int slot = 0;
      for (int c = 0; c < 16; c++) begin
        popa_data_valid = c[0];
        popa_data = (slot == 4) ? 32'h0000_1234 : 32'h0000_0000;
        tick();
        if (!c[0]) begin
          check($sformatf("popa.gap%0d.we", c), 32'(write_enable), 32'd0);
          check($sformatf("popa.gap%0d.busy", c), 32'(popa_busy), 32'd1);
        end else if (slot == 3) begin
          check("popa.s3.we", 32'(write_enable), 32'd0);
          slot++;
        end else if (slot == 4) begin
          check_write("popa.ebx", 3'd1, 32'hFFFF_1234);
          slot++;
        end else begin
          check($sformatf("popa.s%0d.idx", slot), 32'(write_index), 32'(popa_idx[slot]));
          slot++;
        end
      end
      check("popa.done", 32'(popa_done), 32'd1);
    end
    popa_data_valid = 1'b0;
    tick();

    // Reset mid-POPAD after slot 2
    popa_start = 1'b1; popa_dword = 1'b1;
    tick();
    popa_start = 1'b0;
    popa_data_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      popa_data = 32'h100 + 32'(k);
      tick();
    end
    popa_data_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort.we", 32'(write_enable), 32'd0);
    check("abort.data", write_data, 32'd0);
    check("abort.busy", 32'(popa_busy), 32'd0);
    check("abort.dready", 32'(popa_data_ready), 32'd0);
    check("abort.wb_ready", 32'(wb_ready), 32'd0);
    #1;
    reset = 1'b1;
    wb_valid = 1'b1; wb_reg = 3'd0; wb_size = 2'b10; wb_data = 32'h0000_0005;
    tick();
    wb_valid = 1'b0;
    check_write("abort.eax", 3'd0, 32'h0000_0005);
    check("abort.busy2", 32'(popa_busy), 32'd0);
    tick();
    check("abort.idle_we", 32'(write_enable), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
